// File: rtl/arb_mux_if.sv
// arb_mux_if: handshake bundle between N producers, the arbitrating mux
// and a single consumer.
//
// Parameters: DATA_WIDTH, CHANNELS, SEL_WIDTH (must match the arb_mux instance).
// Signals:
//   in_data   packed producer data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid  per-channel request
//   in_ready  per-channel accept (at most one bit high)
//   in_lock   per-channel burst lock (only with ARB_MUX_LOCK_EN)
//   out_data  registered selected data
//   out_valid output register holds a beat
//   out_ready consumer accepts the beat
//   out_slct  index of the channel that produced out_data
// Modports: master = producer/consumer side, slave = arb_mux side.
// Optional feature macro: ARB_MUX_LOCK_EN adds in_lock.
interface arb_mux_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 4,
    parameter int SEL_WIDTH  = 2
);
    logic [CHANNELS*DATA_WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]            in_valid;
    logic [CHANNELS-1:0]            in_ready;
    logic [DATA_WIDTH-1:0]          out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [SEL_WIDTH-1:0]           out_slct;
`ifdef ARB_MUX_LOCK_EN
    logic [CHANNELS-1:0]            in_lock;

    modport master (
        output in_data, in_valid, in_lock, out_ready,
        input  in_ready, out_data, out_valid, out_slct
    );

    modport slave (
        input  in_data, in_valid, in_lock, out_ready,
        output in_ready, out_data, out_valid, out_slct
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_slct
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_slct
    );
`endif
endinterface

// File: rtl/arb_mux.sv
// arb_mux: registered N-channel round-robin arbitrating multiplexer.
//
// Several valid/ready producers share one registered output port. A
// combinational round-robin arbiter picks the next channel starting after
// the last granted one; the winning beat is captured into the output
// register together with its channel index.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  arb_mux_if.slave (in_data/in_valid/in_ready, out_data/out_valid/
//        out_ready/out_slct, and in_lock when ARB_MUX_LOCK_EN is defined)
//
// Optional feature macro: ARB_MUX_LOCK_EN. When defined, a channel that won
// the previous transfer and still asserts both in_lock and in_valid is
// granted again, bypassing round-robin (multi-beat bursts).
module arb_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 4,
    parameter int SEL_WIDTH  = 2
) (
    input logic     clk,
    input logic     rst,
    arb_mux_if.slave bus
);

    logic [SEL_WIDTH-1:0]  last_grant;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [SEL_WIDTH-1:0]  cand;
    logic                  grant_any;
    logic                  load_ok;
    logic                  transfer;
    logic [CHANNELS-1:0]   ready_c;
    logic [DATA_WIDTH-1:0] sel_data;

    logic [DATA_WIDTH-1:0] data_q;
    logic [SEL_WIDTH-1:0]  slct_q;
    logic                  valid_q;

    assign load_ok = ~valid_q | bus.out_ready;

    // Walk candidates from farthest to nearest so the nearest valid channel
    // after last_grant is the one left standing.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            cand = SEL_WIDTH'((int'(last_grant) + k) % CHANNELS);
            if (bus.in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
`ifdef ARB_MUX_LOCK_EN
        if (bus.in_lock[last_grant] && bus.in_valid[last_grant]) begin
            grant_any = 1'b1;
            grant_idx = last_grant;
        end
`endif
        // Nothing may be accepted while reset is held.
        if (rst) begin
            grant_any = 1'b0;
        end
    end

    assign transfer = grant_any & load_ok;
    assign sel_data = bus.in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        ready_c = '0;
        if (transfer) begin
            ready_c[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            slct_q     <= '0;
            last_grant <= SEL_WIDTH'(CHANNELS - 1);
        end else if (transfer) begin
            // A new beat overwrites any beat being consumed this same edge.
            valid_q    <= 1'b1;
            data_q     <= sel_data;
            slct_q     <= grant_idx;
            last_grant <= grant_idx;
        end else if (bus.out_ready) begin
            valid_q    <= 1'b0;
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_data  = data_q;
    assign bus.out_slct  = slct_q;
    assign bus.out_valid = valid_q;

endmodule
